// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the SRAM-like bus bridge: FSM encoding, bus size codes
// and the legal byte-enable set.
package sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Legal enables: read, one byte lane, an aligned half, or a full word.
   function automatic logic wen_illegal(input logic [3:0] wen);
      case (wen)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: wen_illegal = 1'b0;
         default:                   wen_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/sram_like_bridge_size_decode.sv
// Combinational byte-enable decode: bus size, low address bits, direction and
// illegal-pattern flag.
module sram_size_decode
   import sram_like_bridge_pkg::*;
(
   input  logic [3:0] wen,
   input  logic [1:0] addr_lo_in,
   output logic [1:0] size,
   output logic [1:0] addr_lo,
   output logic       wr,
   output logic       illegal
);

   always_comb begin
      size    = SIZE_WORD;
      addr_lo = 2'b00;
      wr      = (wen != 4'b0000);
      illegal = wen_illegal(wen);
      case (wen)
         4'b0001: begin size = SIZE_BYTE; addr_lo = 2'd0; end
         4'b0010: begin size = SIZE_BYTE; addr_lo = 2'd1; end
         4'b0100: begin size = SIZE_BYTE; addr_lo = 2'd2; end
         4'b1000: begin size = SIZE_BYTE; addr_lo = 2'd3; end
         4'b0011: begin size = SIZE_HALF; addr_lo = 2'd0; end
         4'b1100: begin size = SIZE_HALF; addr_lo = 2'd2; end
         4'b0000, 4'b1111: begin size = SIZE_WORD; addr_lo = 2'd0; end
         // Illegal patterns never reach the bus; pass the CPU bits through.
         default: begin size = SIZE_WORD; addr_lo = addr_lo_in; end
      endcase
   end

endmodule

// File: rtl/sram_like_bridge.sv
// CPU-side single-outstanding access to an SRAM-like split addr/data handshake bus,
// with byte-enable decode, illegal-enable rejection and a wait timeout.
module sram_like_bridge
   import sram_like_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_en,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        err
);

   localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

   state_e      state_q, state_d;
   logic        bus_wr_q, bus_wr_d;
   logic [1:0]  bus_size_q, bus_size_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;

   logic [1:0]  dec_size, dec_addr_lo;
   logic        dec_wr, dec_illegal;
   logic        timeout_hit;

   sram_size_decode u_dec (
      .wen        (cpu_wen),
      .addr_lo_in (cpu_addr[1:0]),
      .size       (dec_size),
      .addr_lo    (dec_addr_lo),
      .wr         (dec_wr),
      .illegal    (dec_illegal)
   );

   // Fires on the cycle whose increment would reach the limit.
   assign timeout_hit = (TO_LIMIT != 32'd0) && ((cnt_q + 32'd1) == TO_LIMIT);

   always_comb begin
      state_d     = state_q;
      bus_wr_d    = bus_wr_q;
      bus_size_d  = bus_size_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_en) begin
               if (dec_illegal) begin
                  state_d     = ST_DONE;
                  err_d       = 1'b1;
                  cpu_rdata_d = 32'd0;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = 32'd0;
                  bus_wr_d    = dec_wr;
                  bus_size_d  = dec_size;
                  bus_addr_d  = {cpu_addr[31:2], dec_addr_lo};
                  bus_wdata_d = cpu_wdata;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 32'd1;
            if (bus_addr_ok && bus_data_ok) begin
               state_d     = ST_DONE;
               cpu_rdata_d = bus_wr_q ? 32'd0 : bus_rdata;
            end else if (bus_addr_ok) begin
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               state_d     = ST_DONE;
               err_d       = 1'b1;
               cpu_rdata_d = 32'd0;
            end
         end
         ST_RESP: begin
            cnt_d = cnt_q + 32'd1;
            if (bus_data_ok) begin
               state_d     = ST_DONE;
               cpu_rdata_d = bus_wr_q ? 32'd0 : bus_rdata;
            end else if (timeout_hit) begin
               state_d     = ST_DONE;
               err_d       = 1'b1;
               cpu_rdata_d = 32'd0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_wr_q    <= 1'b0;
         bus_size_q  <= 2'd0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         cpu_rdata_q <= 32'd0;
         err_q       <= 1'b0;
         cnt_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         bus_wr_q    <= bus_wr_d;
         bus_size_q  <= bus_size_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus_req   = (state_q == ST_REQ);
   assign bus_wr    = bus_wr_q;
   assign bus_size  = bus_size_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign err       = err_q;
   assign cpu_stall = cpu_en && (state_q != ST_DONE);

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge (TIMEOUT=4); inputs change 1ns after the
// rising edge, outputs are sampled 2ns after it.
module tb_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_en = 1'b0;
   logic [3:0]  cpu_wen = 4'd0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok = 1'b0;
   logic        bus_data_ok = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        err;

   int errors = 0;
   int checks = 0;

   sram_like_bridge #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b exp 0", bus_req); end
      checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL rst_bus_wr: got %b exp 0", bus_wr); end
      checks++; if (bus_size !== 2'd0) begin errors++; $display("FAIL rst_bus_size: got %0d exp 0", bus_size); end
      checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rst_bus_addr: got %h exp 0", bus_addr); end
      checks++; if (bus_wdata !== 32'd0) begin errors++; $display("FAIL rst_bus_wdata: got %h exp 0", bus_wdata); end
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL rst_cpu_rdata: got %h exp 0", cpu_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", cpu_stall); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_word_read();
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1003; cpu_wdata = 32'h0;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c0: got %b exp 1", cpu_stall); end
      cyc(); bus_addr_ok = 1'b1; #1;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rd_req_c1: got %b exp 1", bus_req); end
      checks++; if (bus_addr !== 32'h1000) begin errors++; $display("FAIL rd_addr: got %h exp 00001000", bus_addr); end
      checks++; if (bus_size !== 2'd2) begin errors++; $display("FAIL rd_size: got %0d exp 2", bus_size); end
      checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL rd_wr: got %b exp 0", bus_wr); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c1: got %b exp 1", cpu_stall); end
      cyc(); bus_addr_ok = 1'b0; #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_req_c2: got %b exp 0", bus_req); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c2: got %b exp 1", cpu_stall); end
      cyc(); bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c3: got %b exp 1", cpu_stall); end
      cyc(); bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall_c4: got %b exp 0", cpu_stall); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", cpu_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b exp 0", err); end
      cpu_en = 1'b0;
      cyc(); #1;
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata_hold: got %h exp deadbeef", cpu_rdata); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_req_idle: got %b exp 0", bus_req); end
   endtask

   task automatic test_byte_write();
      cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h2000; cpu_wdata = 32'h11223344;
      cyc(); bus_addr_ok = 1'b1; #1;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL bw_req: got %b exp 1", bus_req); end
      checks++; if (bus_wr !== 1'b1) begin errors++; $display("FAIL bw_wr: got %b exp 1", bus_wr); end
      checks++; if (bus_size !== 2'd0) begin errors++; $display("FAIL bw_size: got %0d exp 0", bus_size); end
      checks++; if (bus_addr !== 32'h2002) begin errors++; $display("FAIL bw_addr: got %h exp 00002002", bus_addr); end
      checks++; if (bus_wdata !== 32'h11223344) begin errors++; $display("FAIL bw_wdata: got %h exp 11223344", bus_wdata); end
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFFFFFF; #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bw_stall_c2: got %b exp 1", cpu_stall); end
      cyc(); bus_data_ok = 1'b0; #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bw_stall_c3: got %b exp 0", cpu_stall); end
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL bw_rdata: got %h exp 0", cpu_rdata); end
      cpu_en = 1'b0;
      cyc();
   endtask

   // Each row uses the same-cycle addr_ok/data_ok handshake: DONE two cycles after cpu_en.
   task automatic test_size_decode();
      logic [3:0]  t_wen  [7] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000};
      logic [31:0] t_addr [7] = '{32'h5003, 32'h5000, 32'h5000, 32'h5002, 32'h5001, 32'h5000, 32'h5002};
      logic [1:0]  t_size [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
      logic [31:0] t_badr [7] = '{32'h5000, 32'h5001, 32'h5003, 32'h5000, 32'h5002, 32'h5000, 32'h5000};
      for (int i = 0; i < 7; i++) begin
         logic [31:0] rd;
         rd = 32'hA5A50000 | 32'(i);
         cpu_en = 1'b1; cpu_wen = t_wen[i]; cpu_addr = t_addr[i]; cpu_wdata = 32'hC0DE0000 | 32'(i);
         cyc(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = rd; #1;
         checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL sd%0d_req: got %b exp 1", i, bus_req); end
         checks++; if (bus_size !== t_size[i]) begin errors++; $display("FAIL sd%0d_size: got %0d exp %0d", i, bus_size, t_size[i]); end
         checks++; if (bus_addr !== t_badr[i]) begin errors++; $display("FAIL sd%0d_addr: got %h exp %h", i, bus_addr, t_badr[i]); end
         checks++; if (bus_wr !== (t_wen[i] != 4'd0)) begin errors++; $display("FAIL sd%0d_wr: got %b exp %b", i, bus_wr, t_wen[i] != 4'd0); end
         cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL sd%0d_done: got stall %b exp 0", i, cpu_stall); end
         checks++; if (cpu_rdata !== ((t_wen[i] == 4'd0) ? rd : 32'd0)) begin errors++; $display("FAIL sd%0d_rdata: got %h", i, cpu_rdata); end
         cpu_en = 1'b0;
         cyc();
      end
   endtask

   task automatic test_illegal();
      cpu_en = 1'b1; cpu_wen = 4'b0101; cpu_addr = 32'h3000; cpu_wdata = 32'h55AA55AA;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL il_stall_c0: got %b exp 1", cpu_stall); end
      cyc(); #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL il_stall_c1: got %b exp 0", cpu_stall); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL il_err_c1: got %b exp 1", err); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL il_req_c1: got %b exp 0", bus_req); end
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL il_rdata: got %h exp 0", cpu_rdata); end
      cpu_en = 1'b0;
      cyc(); #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL il_err_c2: got %b exp 0", err); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL il_req_c2: got %b exp 0", bus_req); end
   endtask

   task automatic test_timeout();
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h6000;
      for (int c = 1; c <= 4; c++) begin
         cyc(); #1;
         checks++; if (bus_req !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL to_req_c%0d: got req %b stall %b exp 1 1", c, bus_req, cpu_stall); end
      end
      cyc(); #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL to_stall_c5: got %b exp 0", cpu_stall); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_c5: got %b exp 1", err); end
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL to_rdata_c5: got %h exp 0", cpu_rdata); end
      cpu_en = 1'b0;
      cyc(); cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h12345678; #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_stray_req: got %b exp 0", bus_req); end
      cyc(); bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL to_stray_rdata: got %h exp 0", cpu_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_stray_err: got %b exp 0", err); end
      // Still idle: a fresh access must request on the next cycle.
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h6100;
      cyc(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0000BEEF; #1;
      checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h6100) begin errors++; $display("FAIL to_after_req: got req %b addr %h exp 1 00006100", bus_req, bus_addr); end
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_en = 1'b0;
      cyc();
   endtask

   task automatic test_ignored();
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h77777777;
      cyc(); #1;
      checks++; if (bus_req !== 1'b0 || cpu_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL ig_idle: got req %b rdata %h exp 0 0000beef", bus_req, cpu_rdata); end
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h8004;
      cyc(); bus_data_ok = 1'b1; #1;
      cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ig_early_data: got req %b exp 1", bus_req); end
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D; #1;
      cyc(); bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
      checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL ig_done: got stall %b rdata %h exp 0 0badf00d", cpu_stall, cpu_rdata); end
      cpu_en = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h7000; cpu_wdata = 32'h99999999;
      cyc(); bus_addr_ok = 1'b1;
      cyc(); bus_addr_ok = 1'b0; rst = 1'b1;
      cyc(); rst = 1'b0; cpu_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", bus_req); end
      checks++; if (bus_wr !== 1'b0 || bus_size !== 2'd0) begin errors++; $display("FAIL rm_wr_size: got %b %0d exp 0 0", bus_wr, bus_size); end
      checks++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin errors++; $display("FAIL rm_addr_wdata: got %h %h exp 0 0", bus_addr, bus_wdata); end
      checks++; if (cpu_rdata !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL rm_rdata_err: got %h %b exp 0 0", cpu_rdata, err); end
      cyc(); bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
      checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL rm_rdata_after: got %h exp 0", cpu_rdata); end
      checks++; if (bus_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rm_after: got req %b err %b exp 0 0", bus_req, err); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word_read();
      test_byte_write();
      test_size_decode();
      test_illegal();
      test_timeout();
      test_ignored();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
